rr_lock_arbiter: RTL and testbench
==================================

Name: rr_lock_arbiter

Overview:
- Parameterised N-requester round-robin arbiter for a single shared resource. It generalises the two-requester R0/R1 → G0/G1 arbitration to N requesters.
- A requester keeps its grant (lock) for as long as it holds its request, subject to an optional hold-time limit.
- Sits between requesting masters and the shared datapath/bus. Only one grant bit may be asserted at a time.
- Grant outputs are registered, so they can drive resource muxes directly.

Parameters:
- N, 4, number of requesters (2..16).
- ID_W, 2, width of grant_id; must equal ceil(log2(N)).
- MAX_HOLD, 8, maximum consecutive grant cycles per tenure when others wait. 0 = unlimited. Used only with RR_ARB_HOLD_LIMIT_EN.
- HOLD_W, 4, width of the hold counter; must satisfy 2^HOLD_W >= MAX_HOLD.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: reset, synchronous, active-high.
- req, input, N: request vector; req[i] high = requester i wants or holds the resource.
- grant, output, N: registered one-hot grant, or all-zero.
- grant_valid, output, 1: registered; high when any grant bit is set.
- grant_id, output, ID_W: registered index of the current owner; meaningful only when grant_valid=1.

Behaviour:
- Reset (rst sampled high at a clk edge):
  - grant=0, grant_valid=0, grant_id=0.
  - Priority pointer ptr=0; hold counter cnt=0; state=IDLE.
  - This applies even mid-tenure: the grant drops at that same edge.
- States:
  - IDLE: no owner.
  - GRANT: owner = grant_id.
- Winner selection: the first i with req[i]=1, scanning ptr, ptr+1, …, N-1, 0, …, ptr-1 (wrap modulo N).
- IDLE:
  - If req != 0 at an edge, the winner is granted at that edge. Latency is 1 cycle from req sampled to grant visible.
  - On grant: state→GRANT, cnt=0.
  - If req = 0, stay in IDLE.
- GRANT, owner still requesting (req[owner]=1), no preemption: hold the grant; cnt increments, saturating at 2^HOLD_W-1.
- GRANT, owner releases (req[owner]=0 sampled):
  - ptr = owner+1 mod N.
  - At the same edge, grant the winner found from the new ptr among the current req (back-to-back, no bubble cycle), with cnt=0.
  - If no other request is pending, grant=0 and state→IDLE.
- GRANT, preemption (macro enabled only):
  - Condition: MAX_HOLD != 0, cnt == MAX_HOLD-1, req[owner]=1, and some req[j]=1 with j != owner.
  - At that edge, ptr = owner+1 mod N; grant the winner excluding the owner; cnt=0.
  - Net effect: the owner held the grant for exactly MAX_HOLD cycles.
  - If no other requester is waiting, the owner keeps the grant and cnt saturates.
- A preempted owner whose request stays high re-competes normally; it wins again only when the rotation reaches it.
- Simultaneous events:
  - Owner release plus a new request in the same cycle is resolved by the single scan above.
  - A request asserted and deasserted between edges is never seen.
- Invariants (bench asserts every cycle):
  - $onehot0(grant).
  - grant_valid == |grant.
  - grant[grant_id]==1 whenever grant_valid=1.
  - A grant is never issued to a requester whose req was 0 at that edge.
- Fairness: with all N requesting continuously and holds bounded, every requester is granted within N tenures.

Optional Feature:
- Macro: RR_ARB_HOLD_LIMIT_EN.
- Defined: hold-limit preemption is active as described above; MAX_HOLD=0 still means unlimited.
- Undefined:
  - The preemption logic and hold counter are not compiled; MAX_HOLD and HOLD_W are ignored.
  - The owner keeps the grant until it drops req. All other behaviour is identical.

Test Plan:
- Reset: req=4'b1111 with rst=1 for 2 cycles → grant=0000, grant_valid=0. At the first edge with rst=0 → grant=0001, grant_id=0.
- Single requester: req=0100 sampled at edge k → grant=0100, grant_id=2 after edge k. req→0000 → grant=0000, grant_valid=0 after the next edge.
- Back-to-back rotation:
  - req=0101 held, owner 0; req[0] drops → grant=0100 at the next edge, no idle cycle.
  - req[0] reasserts and req[2] drops → grant=0001.
- Wrap-around: owner 3, req=1001; req[3] drops → grant=0001, grant_id=0.
- Hold limit with MAX_HOLD=4 and req=0011 held constantly:
  - Macro defined → grant alternates 0001×4 cycles, 0010×4 cycles, ….
  - Macro undefined → grant=0001 indefinitely.
  - req=0001 alone with macro defined → grant=0001 indefinitely.
- Reset mid-tenure: grant=0100, rst=1 for 1 cycle → grant=0000 after that edge. Then req=0110 → grant=0010, since ptr was reset to 0.

Source files
------------

// File: rtl/rr_lock_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_lock_arbiter                                              |
// | Description : N-requester round-robin arbiter with grant lock; optional    |
// |               hold-limit preemption when RR_ARB_HOLD_LIMIT_EN is defined.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rr_lock_arbiter #(
  parameter int N        = 4,
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [ID_W-1:0] grant_id
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [N-1:0] c_one = N'(1);

  state_t          r_state;
  logic [N-1:0]    r_grant;
  logic            r_grant_valid;
  logic [ID_W-1:0] r_grant_id;
  logic [ID_W-1:0] r_ptr;

  logic [N-1:0]    w_owner_mask;
  logic            w_owner_req;
  logic [ID_W-1:0] w_owner_next;
  logic [ID_W-1:0] w_scan_ptr;
  logic [N-1:0]    w_scan_req;
  logic            w_any;
  logic [ID_W-1:0] w_win_id;
  logic [N-1:0]    w_win_onehot;
  logic            w_preempt;

  if ((N < 2) || (N > 16)) begin : g_bad_n
    $error("rr_lock_arbiter: N must be within 2..16");
  end
  if ($clog2(N) != ID_W) begin : g_bad_id_w
    $error("rr_lock_arbiter: ID_W must equal clog2(N)");
  end
  if ((MAX_HOLD < 0) || ((1 << HOLD_W) < MAX_HOLD)) begin : g_bad_hold
    $error("rr_lock_arbiter: HOLD_W too narrow for MAX_HOLD");
  end

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
    return ID_W'((int'(base) + off) % N);
  endfunction

  // Owner bit is masked out of the scan while in GRANT: on release it is zero
  // anyway, and on preemption the owner must not win again.
  assign w_owner_mask = c_one << r_grant_id;
  assign w_owner_req  = |(req & w_owner_mask);
  assign w_owner_next = wrap_add(r_grant_id, 1);
  assign w_scan_ptr   = (r_state == GRANT) ? w_owner_next : r_ptr;
  assign w_scan_req   = (r_state == GRANT) ? (req & ~w_owner_mask) : req;

  always_comb begin
    w_any    = 1'b0;
    w_win_id = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_scan_req[wrap_add(w_scan_ptr, k)]) begin
        w_any    = 1'b1;
        w_win_id = wrap_add(w_scan_ptr, k);
      end
    end
  end

  assign w_win_onehot = c_one << w_win_id;

`ifdef RR_ARB_HOLD_LIMIT_EN
  localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] c_cnt_max   = '1;

  logic [HOLD_W-1:0] r_cnt;

  // In GRANT, w_any means some requester other than the owner is waiting.
  assign w_preempt = (MAX_HOLD != 0) && (r_state == GRANT) && w_owner_req &&
                     (r_cnt == c_hold_last) && w_any;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if ((r_state == IDLE) || !w_owner_req || w_preempt) begin
      r_cnt <= '0;
    end else if (r_cnt != c_cnt_max) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_preempt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
      r_ptr         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant       <= w_win_onehot;
            r_grant_id    <= w_win_id;
            r_grant_valid <= 1'b1;
            r_state       <= GRANT;
          end
        end
        GRANT: begin
          if (!w_owner_req || w_preempt) begin
            r_ptr <= w_owner_next;
            if (w_any) begin
              r_grant    <= w_win_onehot;
              r_grant_id <= w_win_id;
            end else begin
              r_grant       <= '0;
              r_grant_valid <= 1'b0;
              r_state       <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;
  assign grant_id    = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_rr_lock_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rr_lock_arbiter                                           |
// | Description : Self-checking bench for rr_lock_arbiter (N=4, MAX_HOLD=4).   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_rr_lock_arbiter;

  localparam int N        = 4;
  localparam int ID_W     = 2;
  localparam int MAX_HOLD = 4;
  localparam int HOLD_W   = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    grant;
  logic            grant_valid;
  logic [ID_W-1:0] grant_id;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: owner index (-1 = none), rotation pointer, cycles held.
  int  m_owner  = -1;
  int  m_ptr    = 0;
  int  m_tenure = 0;
  bit  m_live   = 1'b0;

  rr_lock_arbiter #(
    .N(N), .ID_W(ID_W), .MAX_HOLD(MAX_HOLD), .HOLD_W(HOLD_W)
  ) dut (
    .clk(clk), .rst(rst), .req(req),
    .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  function automatic int pick(input int ptr, input logic [N-1:0] r, input int excl);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (idx != excl && r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] owner_vec(input int o);
    logic [N-1:0] v;
    v = '0;
    if (o >= 0) v[o] = 1'b1;
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_tenure = 0; m_live = 1'b1;
    end else if (m_live) begin
      if (m_owner < 0) begin
        m_owner = pick(m_ptr, req, -1);
        m_tenure = 1;
      end else if (!req[m_owner]) begin
        m_ptr = (m_owner + 1) % N;
        m_owner = pick(m_ptr, req, -1);
        m_tenure = 1;
      end else begin
        bit preempt;
        preempt = 1'b0;
`ifdef RR_ARB_HOLD_LIMIT_EN
        preempt = (MAX_HOLD != 0) && (m_tenure == MAX_HOLD) && (pick(0, req, m_owner) >= 0);
`endif
        if (preempt) begin
          m_ptr = (m_owner + 1) % N;
          m_owner = pick(m_ptr, req, m_owner);
          m_tenure = 1;
        end else begin
          m_tenure = m_tenure + 1;
        end
      end
    end
  end

  // Per-cycle compare against the model plus structural invariants.
  always @(negedge clk) begin
    if (m_live) begin
      n_vec++;
      if (grant !== owner_vec(m_owner) || grant_valid !== (m_owner >= 0) ||
          (m_owner >= 0 && grant_id !== ID_W'(m_owner))) begin
        n_err++;
        $display("FAIL model t=%0t: got grant=%b valid=%b id=%0d, want grant=%b valid=%b id=%0d",
                 $time, grant, grant_valid, grant_id, owner_vec(m_owner), m_owner >= 0, m_owner);
      end
      n_vec++;
      if (!$onehot0(grant) || grant_valid !== (|grant) ||
          (grant_valid && grant[grant_id] !== 1'b1)) begin
        n_err++;
        $display("FAIL invariant t=%0t: got grant=%b valid=%b id=%0d, want onehot0 consistent",
                 $time, grant, grant_valid, grant_id);
      end
    end
  end

  // Apply one vector at the negedge, then wait for the next negedge.
  task automatic apply(input logic [N-1:0] r, input logic rs);
    req = r;
    rst = rs;
    @(negedge clk);
  endtask

  task automatic expect_lit(input string name, input logic [N-1:0] g, input logic v,
                            input logic [ID_W-1:0] id);
    n_vec++;
    if (grant !== g || grant_valid !== v || (v && grant_id !== id)) begin
      n_err++;
      $display("FAIL %s: got grant=%b valid=%b id=%0d, want grant=%b valid=%b id=%0d",
               name, grant, grant_valid, grant_id, g, v, id);
    end
  endtask

  logic [N-1:0] table_req [16] = '{4'b1111, 4'b1010, 4'b0110, 4'b0000, 4'b1001, 4'b0111,
                                   4'b1100, 4'b0011, 4'b1110, 4'b0101, 4'b1011, 4'b0001,
                                   4'b1111, 4'b1000, 4'b1101, 4'b0010};

  initial begin
    logic [N-1:0] exp_g;
    @(negedge clk);
    // Reset with all requesting
    apply(4'b1111, 1'b1); expect_lit("reset_1", 4'b0000, 1'b0, 2'd0);
    apply(4'b1111, 1'b1); expect_lit("reset_2", 4'b0000, 1'b0, 2'd0);
    apply(4'b1111, 1'b0); expect_lit("first_grant", 4'b0001, 1'b1, 2'd0);
    apply(4'b0000, 1'b0); expect_lit("release_idle", 4'b0000, 1'b0, 2'd0);
    // Single requester
    apply(4'b0100, 1'b0); expect_lit("single_grant", 4'b0100, 1'b1, 2'd2);
    apply(4'b0000, 1'b0); expect_lit("single_release", 4'b0000, 1'b0, 2'd0);
    // Back-to-back rotation
    apply(4'b0101, 1'b0); expect_lit("b2b_owner0", 4'b0001, 1'b1, 2'd0);
    apply(4'b0101, 1'b0); expect_lit("b2b_hold0", 4'b0001, 1'b1, 2'd0);
    apply(4'b0100, 1'b0); expect_lit("b2b_to2", 4'b0100, 1'b1, 2'd2);
    apply(4'b0001, 1'b0); expect_lit("b2b_to0", 4'b0001, 1'b1, 2'd0);
    // Wrap-around from owner 3
    apply(4'b1000, 1'b0); expect_lit("wrap_owner3", 4'b1000, 1'b1, 2'd3);
    apply(4'b1001, 1'b0); expect_lit("wrap_hold3", 4'b1000, 1'b1, 2'd3);
    apply(4'b0001, 1'b0); expect_lit("wrap_to0", 4'b0001, 1'b1, 2'd0);
    // Hold limit: pointer is 1 after this release, so requester 1 wins first
    apply(4'b0000, 1'b0); expect_lit("hold_idle", 4'b0000, 1'b0, 2'd0);
    for (int i = 0; i < 12; i++) begin
      apply(4'b0011, 1'b0);
`ifdef RR_ARB_HOLD_LIMIT_EN
      exp_g = ((i / MAX_HOLD) % 2 == 0) ? 4'b0010 : 4'b0001;
`else
      exp_g = 4'b0010;
`endif
      expect_lit("hold_pair", exp_g, 1'b1, (exp_g == 4'b0010) ? 2'd1 : 2'd0);
    end
    for (int i = 0; i < 10; i++) begin
      apply(4'b0001, 1'b0); expect_lit("hold_alone", 4'b0001, 1'b1, 2'd0);
    end
    // Reset mid-tenure
    apply(4'b0100, 1'b0); expect_lit("mid_owner2", 4'b0100, 1'b1, 2'd2);
    apply(4'b0100, 1'b1); expect_lit("mid_reset", 4'b0000, 1'b0, 2'd0);
    apply(4'b0110, 1'b0); expect_lit("mid_after", 4'b0010, 1'b1, 2'd1);
    // Mixed directed patterns checked by the model only
    for (int rep = 0; rep < 3; rep++) begin
      for (int j = 0; j < 16; j++) begin
        for (int h = 0; h <= (j + rep) % 3; h++) apply(table_req[j], 1'b0);
      end
    end
    apply(4'b1111, 1'b0);
    for (int i = 0; i < 20; i++) apply(4'b1111, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
